// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter. Takes one Word_Len-bit word per valid/ready
// handshake and sends start bit, data LSB first, optional even parity and one
// stop bit on Uart_Tx. All outputs are registered. The line idles high.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line high, ready high, waiting for a word
// S_START | start bit (0) for CLKS_PER_BIT cycles
// S_DATA  | data bits, LSB first, CLKS_PER_BIT cycles each
// S_PARITY| even parity of the latched word (UART_TX_PARITY_EN only)
// S_STOP  | stop bit (1); on wrap return to idle and raise ready
`timescale 1ns/1ps

module uart_tx_core #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 9600,
   parameter int Word_Len  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [Word_Len-1:0] tx_data_in,
   input  logic                tx_data_valid,
   output logic                Uart_Tx,
   output logic                tx_data_ready
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W        = $clog2(Word_Len);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(Word_Len - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
   logic [Word_Len-1:0] shift_q, shift_d;
   logic                tx_q, tx_d;
   logic                ready_q, ready_d;
`ifdef UART_TX_PARITY_EN
   logic                parity_q, parity_d;
`endif
   logic                baud_wrap;

   assign baud_wrap     = (cnt_q == CNT_LAST);
   assign Uart_Tx       = tx_q;
   assign tx_data_ready = ready_q;

   // State and datapath registers; reset forces the line high and aborts any frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         ready_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         ready_q   <= ready_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   // Next-state logic; tx_d is the value the line takes after this edge,
   // so the start bit appears on the very edge that accepts the word.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      ready_d   = ready_q;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif

      if (state_q != S_IDLE) begin
         cnt_d = baud_wrap ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            tx_d    = 1'b1;
            ready_d = 1'b1;
            cnt_d   = '0;
            if (tx_data_valid && ready_q) begin
               shift_d   = tx_data_in;
`ifdef UART_TX_PARITY_EN
               parity_d  = ^tx_data_in;
`endif
               bit_idx_d = '0;
               tx_d      = 1'b0;
               ready_d   = 1'b0;
               state_d   = S_START;
            end
         end
         S_START: begin
            if (baud_wrap) begin
               tx_d    = shift_q[0];
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_wrap) begin
               if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = parity_q;
                  state_d = S_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = S_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_wrap) begin
               tx_d    = 1'b1;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (baud_wrap) begin
               tx_d    = 1'b1;
               ready_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            tx_d    = 1'b1;
            ready_d = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core with a short bit period (8 clocks per bit).
// The expected line waveform is built from the frame rule: bit k of the frame
// (start, data LSB first, optional parity, stop) occupies clock cycles
// k*CPB .. k*CPB+CPB-1 after the accept edge.
`timescale 1ns/1ps

module tb_uart_tx_core;

   localparam int TB_CLK_FREQ = 80;
   localparam int TB_BAUD     = 10;
   localparam int W           = 8;
   localparam int CPB         = TB_CLK_FREQ / TB_BAUD;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS       = W + 3;
`else
   localparam int NBITS       = W + 2;
`endif
   localparam int FRAME       = NBITS * CPB;
   localparam int WAIT_LIMIT  = 4 * FRAME;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] tx_data_in;
   logic         tx_data_valid;
   logic         Uart_Tx;
   logic         tx_data_ready;

   int n_checks = 0;
   int n_fail   = 0;

   logic exp_bits [NBITS];

   uart_tx_core #(
      .CLK_FREQ (TB_CLK_FREQ),
      .BAUD_RATE(TB_BAUD),
      .Word_Len (W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .tx_data_in   (tx_data_in),
      .tx_data_valid(tx_data_valid),
      .Uart_Tx      (Uart_Tx),
      .tx_data_ready(tx_data_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic build_frame(input logic [W-1:0] word);
      exp_bits[0] = 1'b0;
      for (int j = 0; j < W; j++) exp_bits[1 + j] = word[j];
`ifdef UART_TX_PARITY_EN
      exp_bits[W + 1] = ^word;
`endif
      exp_bits[NBITS - 1] = 1'b1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!tx_data_ready && n < WAIT_LIMIT) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", 32'(tx_data_ready), 32'd1);
   endtask

   // Called on a negedge. keep_valid leaves valid high at the end (back-to-back);
   // poke drives a different word with valid mid-frame, which must be ignored.
   task automatic send_frame(input logic [W-1:0] word, input bit keep_valid, input bit poke);
      wait_ready();
      build_frame(word);
      tx_data_in    = word;
      tx_data_valid = 1'b1;
      @(posedge clk);
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         if (i == 0 && !keep_valid) tx_data_valid = 1'b0;
         if (poke && i == FRAME / 2) begin
            tx_data_in    = word ^ 8'h6B;
            tx_data_valid = 1'b1;
         end
         if (poke && i == FRAME / 2 + 2) tx_data_valid = 1'b0;
         check($sformatf("line[%0d]", i), 32'(Uart_Tx), 32'(exp_bits[i / CPB]));
         check($sformatf("busy[%0d]", i), 32'(tx_data_ready), 32'd0);
      end
      @(negedge clk);
      check("end_line", 32'(Uart_Tx), 32'd1);
      check("end_ready", 32'(tx_data_ready), 32'd1);
   endtask

   initial begin
      #(40_000 * 10);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] w;
      reset         = 1'b0;
      tx_data_in    = '0;
      tx_data_valid = 1'b0;
      #50;
      check("rst_line", 32'(Uart_Tx), 32'd1);
      check("rst_ready", 32'(tx_data_ready), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_line", 32'(Uart_Tx), 32'd1);
      end
      check("idle_ready", 32'(tx_data_ready), 32'd1);

      // Basic frame, then a frame with a mid-frame valid pulse on new data.
      send_frame(8'h41, 1'b0, 1'b0);
      send_frame(8'h41, 1'b0, 1'b1);

      // Back-to-back with valid held: exactly one idle cycle between frames.
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b0, 1'b0);

`ifdef UART_TX_PARITY_EN
      send_frame(8'h07, 1'b0, 1'b0);
      send_frame(8'h03, 1'b0, 1'b0);
`endif

      // Reset during data bit 3 must return the line high with no clock edge.
      repeat (3) @(negedge clk);
      tx_data_in    = 8'h9C;
      tx_data_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tx_data_valid = 1'b0;
      repeat (4 * CPB + 1) @(negedge clk);
      check("pre_rst_bit3", 32'(Uart_Tx), 32'd1);
      reset = 1'b0;
      #1;
      check("async_line", 32'(Uart_Tx), 32'd1);
      check("async_ready", 32'(tx_data_ready), 32'd1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      send_frame(8'h55, 1'b0, 1'b0);

      // Randomised words, gaps, back-to-back and mid-frame pokes.
      for (int k = 0; k < 20; k++) begin
         w = W'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send_frame(w, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      end
      tx_data_valid = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
